// File: rtl/mips_fetch_sequencer.sv
// rtl/mips_fetch_sequencer.sv - MIPS-lite instruction fetch and PC sequencing front end
module mips_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        reg_jump,
    input  logic [31:0] reg_target,
    input  logic        br_taken,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic [31:0] retired_count,
    output logic        fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;
    logic [7:0]  tmo_q, tmo_d;

    logic [31:0] link;
    logic [31:0] br_off;

    assign link   = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // State register; reset forces FETCH so req/valid drop without a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
            fault_q <= 1'b0;
            tmo_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: fetch with ack timeout, then retire and pick the next pc by priority
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        fault_d = fault_q;
        tmo_d   = tmo_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    tmo_d   = 8'h0;
                    state_d = ISSUE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_LIMIT) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    if (reg_jump && (reg_target[1:0] != 2'b00)) begin
                        // misaligned register target: retire but keep pc and stop
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        if (reg_jump)
                            pc_d = reg_target;
                        else if (jump)
                            pc_d = {link[31:28], instr_q[25:0], 2'b00};
                        else if (br_taken)
                            pc_d = link + br_off;
                        else
                            pc_d = link;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign imem_req      = reset_n && (state_q == FETCH);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[31:26];
    assign instr_valid   = (state_q == ISSUE);
    assign pc            = pc_q;
    assign link_addr     = link;
    assign retired_count = count_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// tb/tb_mips_fetch_sequencer.sv - scoreboard bench for mips_fetch_sequencer
module tb_mips_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        reg_jump;
    logic [31:0] reg_target;
    logic        br_taken;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [31:0] retired_count;
    logic        fault;

    logic        ack_en;
    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct {
        logic        j;
        logic        rj;
        logic [31:0] rt;
        logic        bt;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   retire_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = mem[imem_addr[9:2]];

    mips_fetch_sequencer #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .reg_jump(reg_jump), .reg_target(reg_target), .br_taken(br_taken),
        .pc(pc), .link_addr(link_addr), .retired_count(retired_count), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: on every retirement pop the expected entry and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (instr_valid && instr_ready) begin
                retire_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ret_pc", pc, e.pc);
                    check("ret_instr", instr, e.instr);
                    check("ret_opcode", {26'h0, opcode}, {26'h0, e.instr[31:26]});
                    check("ret_link", link_addr, e.pc + 32'd4);
                    check("ret_count", retired_count, e.count);
                end
            end
        end
    end

    vec_t vecs[9];

    initial begin
        int n;
        int reqs;
        exp_t e;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]    = 32'h2001_0001;
        mem[1]    = 32'h2002_0002;
        mem[2]    = 32'h0022_1820;
        mem[3]    = 32'h0000_0000;
        mem[4]    = 32'h1000_FFFF;
        mem[5]    = 32'h0800_0040;
        mem[8'h40] = 32'h0800_0040;
        mem[8'h80] = 32'h03E0_0008;

        vecs[0] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0000, 32'h2001_0001};
        vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0004, 32'h2002_0002};
        vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0008, 32'h0022_1820};
        vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_000C, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 32'h1000_FFFF};
        vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 32'h1000_FFFF};
        vecs[6] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0014, 32'h0800_0040};
        vecs[7] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h0000_0100, 32'h0800_0040};
        vecs[8] = '{1'b0, 1'b1, 32'h202, 1'b0, 32'h0000_0200, 32'h03E0_0008};

        reset_n = 1'b0; ack_en = 1'b1; instr_ready = 1'b0;
        jump = 1'b0; reg_jump = 1'b0; reg_target = 32'h0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_count", retired_count, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);

        // Directed retirement vectors
        for (int v = 0; v < 9; v++) begin
            n = 0;
            while (!instr_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!instr_valid) begin
                check("wait_valid_timeout", 32'd0, 32'd1);
                break;
            end
            e.pc = vecs[v].epc; e.instr = vecs[v].einstr; e.count = 32'(v);
            exp_q.push_back(e);
            jump = vecs[v].j; reg_jump = vecs[v].rj; reg_target = vecs[v].rt; br_taken = vecs[v].bt;
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            jump = 1'b0; reg_jump = 1'b0; reg_target = 32'h0; br_taken = 1'b0;
        end

        // Misaligned jspal: halted, retired, no more requests
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (imem_req) reqs++;
            @(negedge clk);
        end
        check("halt_reqs", 32'(reqs), 32'd0);
        check("halt_fault", {31'h0, fault}, 32'h1);
        check("halt_count", retired_count, 32'd9);
        check("halt_pc", pc, 32'h200);
        check("halt_valid", {31'h0, instr_valid}, 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("sb_retired", 32'(retire_cyc.size()), 32'd9);
        if (retire_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                check("seq_issue_cycles", 32'(retire_cyc[i] - retire_cyc[i-1]), 32'd2);
        end

        // Ack timeout
        reset_n = 1'b0; ack_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (imem_req) reqs++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 32'(reqs), 32'd4);
        check("tmo_fault", {31'h0, fault}, 32'h1);
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("tmo_late_ack_valid", {31'h0, instr_valid}, 32'h0);
        check("tmo_late_ack_req", {31'h0, imem_req}, 32'h0);
        check("tmo_pc", pc, 32'h0);

        // Asynchronous reset in the middle of ISSUE
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("async_pre_valid", {31'h0, instr_valid}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_valid", {31'h0, instr_valid}, 32'h0);
        check("async_req", {31'h0, imem_req}, 32'h0);
        check("async_pc", pc, 32'h0);
        check("async_fault", {31'h0, fault}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("restart_valid", {31'h0, instr_valid}, 32'h1);
        check("restart_instr", instr, 32'h2001_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
- Instruction-fetch and PC-sequencing front end for the MIPS-lite core.
- Fetches instruction words from instruction memory over a req/ack handshake and holds the word in an instruction register (IR).
- Presents the IR opcode field to the control decoder and the full word to the datapath.
- Computes the next PC from the control decoder's jump outputs and the datapath's resolved branch decision, covering beq, bltzal, baln and jspal.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ACK_TIMEOUT, 16, maximum cycles imem_req may stay high without imem_ack before a fault is raised; legal range 1..255.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  32  fetch address; equals pc whenever imem_req=1.
imem_ack  in  1  instruction memory has returned the word this cycle.
imem_rdata  in  32  instruction word; sampled when imem_req & imem_ack.
instr  out  32  IR contents.
opcode  out  6  instr[31:26], drives the control decoder input.
instr_valid  out  1  IR holds an unretired instruction.
instr_ready  in  1  datapath retires the instruction this cycle; branch inputs are valid only in this cycle.
jump  in  1  control decoder jump (opcode 2).
reg_jump  in  1  register-target jump (jspal).
reg_target  in  32  jspal target address.
br_taken  in  1  resolved condition for beq, bltzal or baln.
pc  out  32  address of the instruction in IR.
link_addr  out  32  pc+4, used by the bltzal, baln and jspal link writes.
retired_count  out  32  number of retired instructions; wraps.
fault  out  1  sticky error flag.

Behaviour:
- States: FETCH, ISSUE, HALT. Reset enters FETCH.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_count=0, fault=0, timeout counter=0.
- Reset is asynchronous. Reset asserted mid-fetch or mid-issue drops imem_req and instr_valid immediately, and the in-flight memory response is discarded.
- FETCH:
  - imem_req=1 and imem_addr=pc from the first cycle after reset release.
  - On imem_ack: IR<=imem_rdata, timeout counter<=0, go to ISSUE.
  - Minimum latency is 1 cycle (ack in the same cycle as req); next cycle instr_valid=1.
  - Timeout counter increments each FETCH cycle without ack. When it reaches ACK_TIMEOUT: fault<=1, go to HALT, imem_req drops.
- ISSUE:
  - instr_valid=1 and imem_req=0. IR and pc are stable until instr_ready.
  - On instr_ready, next pc is chosen by priority:
    1. reg_jump -> reg_target
    2. jump -> {link_addr[31:28], instr[25:0], 2'b00}
    3. br_taken -> link_addr + (sign-extended instr[15:0] << 2)
    4. otherwise -> link_addr
  - Also on instr_ready: retired_count+=1 (32-bit wrap, no saturation); go to FETCH; instr_valid=0 the next cycle.
  - Simultaneous reg_jump, jump and br_taken resolve by the priority above; no fault.
  - reg_jump with reg_target[1:0]!=0: fault<=1, go to HALT, pc unchanged, the instruction still retires (count increments).
- HALT: all outputs frozen, imem_req=0, instr_valid=0. Exit only via reset.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
- link_addr is combinational pc+4.
- Branch inputs are ignored outside ISSUE & instr_ready.
- imem_ack outside FETCH is ignored.

Test Plan:
- Sequential fetch: RESET_PC=0, memory acks same cycle, instr_ready asserted one cycle after every instr_valid -> pc walks 0,4,8,C; each issue takes 2 cycles; retired_count=4 after four retirements.
- Branch: beq word 0x1000_FFFF at pc=0x10 with br_taken=1 -> next pc=0x10. With br_taken=0 -> next pc=0x14.
- Jump and jspal: j 0x0800_0040 at pc=0x100 -> next pc=0x0000_0100. reg_jump=1, reg_target=0x200 together with jump=1 -> next pc=0x200 (reg_jump wins).
- Misaligned jspal: reg_target=0x202 -> fault=1, HALT, retired_count increments, no further imem_req.
- Timeout: ACK_TIMEOUT=4, imem_ack held low -> imem_req high exactly 4 cycles, then fault=1; a later imem_ack is ignored.
- Async reset: assert reset_n=0 mid-ISSUE with instr_valid=1 -> instr_valid=0 and pc=RESET_PC immediately without a clock edge; after release, a fetch restarts at RESET_PC.
